// File: rtl/mem_access_arbiter.sv
// N-channel round-robin arbiter and access mux in front of the shared register memory.
// Build option ACCESS_ARB_MASTER_PREEMPT_EN: channel 0 has priority and preempts other owners.
module mem_access_arbiter #(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 12,
  parameter int MAX_HOLD = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              req,
  output logic [N_CH-1:0]              grant,
  input  logic [N_CH-1:0][ADDR_W-1:0]  ch_read_addr,
  input  logic [N_CH-1:0][ADDR_W-1:0]  ch_write_addr,
  input  logic [N_CH-1:0]              ch_write,
  input  logic [N_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic [ADDR_W-1:0]            read_addr,
  output logic [ADDR_W-1:0]            write_addr,
  output logic                         write,
  output logic [DATA_W-1:0]            write_node,
  input  logic [DATA_W-1:0]            read_node
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic [PW-1:0]     owner, owner_nxt, pick;
  logic              pick_vld, other, hold_hit, preempt;

  function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] a, int b);
    return PW'((int'(a) + b) % N_CH);
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant_q[i]) owner = PW'(i);
  end

  assign owner_nxt = wrap_add(owner, 1);

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_vld && req[wrap_add(rr_ptr_q, i)]) begin
        pick     = wrap_add(rr_ptr_q, i);
        pick_vld = 1'b1;
      end
    end
`ifdef ACCESS_ARB_MASTER_PREEMPT_EN
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    other      = |(req & ~grant_q);
    hold_hit   = (MAX_HOLD != 0) && other && (hold_cnt_q == HOLD_LIM);
    preempt    = 1'b0;
`ifdef ACCESS_ARB_MASTER_PREEMPT_EN
    if (owner == '0) hold_hit = 1'b0;
    preempt = (owner != '0) && req[0];
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          hold_cnt_d    = '0;
          state_d       = OWN;
        end
      end
      OWN: begin
        // A req drop and a revoke in the same cycle release once, advancing rr_ptr once.
        if (!req[owner] || hold_hit) begin
          grant_d    = '0;
          rr_ptr_d   = owner_nxt;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (preempt) begin
          grant_d    = '0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (other && hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Datapath follows the registered grant; reset kills the write strobe immediately.
  always_comb begin
    read_addr  = '0;
    write_addr = '0;
    write_node = '0;
    write      = 1'b0;
    if (state_q == OWN) begin
      read_addr  = ch_read_addr[owner];
      write_addr = ch_write_addr[owner];
      write_node = ch_wdata[owner];
      write      = ch_write[owner] & ~reset;
    end
  end

  assign grant = grant_q;
  assign rdata = read_node;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter (N_CH=2, MAX_HOLD=4); expected per-cycle outputs queued at drive time.
module tb_mem_access_arbiter;
  localparam int N_CH = 2, ADDR_W = 5, DATA_W = 12, MAX_HOLD = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N_CH-1:0]             req;
  logic [N_CH-1:0]             grant;
  logic [N_CH-1:0][ADDR_W-1:0] ch_read_addr, ch_write_addr;
  logic [N_CH-1:0]             ch_write;
  logic [N_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]           rdata, write_node, read_node;
  logic [ADDR_W-1:0]           read_addr, write_addr;
  logic                        write;

  typedef struct {
    string           tag;
    logic [1:0]      g;
    logic            w;
    logic [4:0]      ra, wa;
    logic [11:0]     wn;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0, n_fail = 0;

  mem_access_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .ch_read_addr(ch_read_addr), .ch_write_addr(ch_write_addr), .ch_write(ch_write),
    .ch_wdata(ch_wdata), .rdata(rdata), .read_addr(read_addr), .write_addr(write_addr),
    .write(write), .write_node(write_node), .read_node(read_node)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle and queue what the outputs must show during it.
  task automatic cyc(string tag, logic [1:0] r, logic [1:0] w, logic rs, logic [1:0] eg);
    exp_t e;
    req       = r;
    ch_write  = w;
    reset     = rs;
    read_node = 12'($urandom);
    e.tag = tag; e.g = eg; e.w = 1'b0; e.ra = '0; e.wa = '0; e.wn = '0;
    if (eg == 2'b01) begin
      e.ra = 5'd7; e.wa = 5'd3; e.wn = 12'hABC; e.w = w[0] & ~rs;
    end else if (eg == 2'b10) begin
      e.ra = 5'd9; e.wa = 5'd21; e.wn = 12'h123; e.w = w[1] & ~rs;
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.tag, ".grant"}, 64'(grant), 64'(cur.g));
      chk({cur.tag, ".write"}, 64'(write), 64'(cur.w));
      chk({cur.tag, ".raddr"}, 64'(read_addr), 64'(cur.ra));
      chk({cur.tag, ".waddr"}, 64'(write_addr), 64'(cur.wa));
      chk({cur.tag, ".wnode"}, 64'(write_node), 64'(cur.wn));
      chk({cur.tag, ".rdata"}, 64'(rdata), 64'(read_node));
      chk({cur.tag, ".onehot"}, 64'($onehot0(grant)), 64'd1);
    end
  end

  initial begin
    reset = 1'b1; req = '0; ch_write = '0; read_node = '0;
    ch_read_addr[0] = 5'd7;  ch_write_addr[0] = 5'd3;  ch_wdata[0] = 12'hABC;
    ch_read_addr[1] = 5'd9;  ch_write_addr[1] = 5'd21; ch_wdata[1] = 12'h123;
    @(posedge clk); #1;

    repeat (3) cyc("rst", 2'b00, 2'b11, 1'b1, 2'b00);

    // ch0 single access
    cyc("t2_idle", 2'b01, 2'b01, 1'b0, 2'b00);
    cyc("t2_gnt",  2'b01, 2'b01, 1'b0, 2'b01);
    cyc("t2_drop", 2'b00, 2'b01, 1'b0, 2'b01);
    cyc("t2_rel",  2'b00, 2'b00, 1'b0, 2'b00);
    // ch1 single access leaves rr_ptr at 0
    cyc("c1_idle", 2'b10, 2'b10, 1'b0, 2'b00);
    cyc("c1_gnt",  2'b10, 2'b10, 1'b0, 2'b10);
    cyc("c1_drop", 2'b00, 2'b10, 1'b0, 2'b10);
    cyc("c1_ign",  2'b00, 2'b10, 1'b0, 2'b00);
    // both request, rr_ptr=0 -> ch0, then ch1 after one idle cycle
    cyc("t3_idle", 2'b11, 2'b10, 1'b0, 2'b00);
    cyc("t3_g0",   2'b11, 2'b10, 1'b0, 2'b01);
    cyc("t3_drop", 2'b10, 2'b11, 1'b0, 2'b01);
    cyc("t3_gap",  2'b10, 2'b10, 1'b0, 2'b00);
`ifndef ACCESS_ARB_MASTER_PREEMPT_EN
    // hold limit: ch1 owns, ch0 waits 4 cycles, then forced release
    cyc("t4_w0",   2'b11, 2'b10, 1'b0, 2'b10);
    cyc("t4_w1",   2'b11, 2'b00, 1'b0, 2'b10);
    cyc("t4_w2",   2'b11, 2'b10, 1'b0, 2'b10);
    cyc("t4_w3",   2'b11, 2'b00, 1'b0, 2'b10);
    cyc("t4_gap",  2'b11, 2'b00, 1'b0, 2'b00);
    cyc("t4_g0",   2'b11, 2'b01, 1'b0, 2'b01);
`else
    cyc("t4p_g1",  2'b11, 2'b10, 1'b0, 2'b10);
    cyc("t4p_gap", 2'b11, 2'b00, 1'b0, 2'b00);
    cyc("t4p_g0",  2'b11, 2'b01, 1'b0, 2'b01);
`endif
    cyc("t5_rel0", 2'b10, 2'b00, 1'b0, 2'b01);
    cyc("t5_gap",  2'b10, 2'b10, 1'b0, 2'b00);
    cyc("t5_g1",   2'b10, 2'b10, 1'b0, 2'b10);
    // reset mid-OWN: write dies at once, grant next edge, rr_ptr back to 0
    cyc("t5_rst",  2'b10, 2'b10, 1'b1, 2'b10);
    cyc("t5_idle", 2'b11, 2'b00, 1'b0, 2'b00);
    cyc("t5_rr0",  2'b11, 2'b01, 1'b0, 2'b01);
    // ch0 leaves, ch1 owns, then ch0 requests again
    cyc("t6_rel0", 2'b10, 2'b00, 1'b0, 2'b01);
    cyc("t6_gap",  2'b10, 2'b00, 1'b0, 2'b00);
    cyc("t6_g1",   2'b10, 2'b10, 1'b0, 2'b10);
`ifdef ACCESS_ARB_MASTER_PREEMPT_EN
    cyc("t6_req0", 2'b11, 2'b00, 1'b0, 2'b10);
    cyc("t6_rev",  2'b11, 2'b00, 1'b0, 2'b00);
    cyc("t6_g0a",  2'b11, 2'b01, 1'b0, 2'b01);
    cyc("t6_g0b",  2'b11, 2'b00, 1'b0, 2'b01);
    cyc("t6_g0c",  2'b11, 2'b01, 1'b0, 2'b01);
`else
    cyc("t6_req0", 2'b11, 2'b00, 1'b0, 2'b10);
    cyc("t6_keep1",2'b11, 2'b10, 1'b0, 2'b10);
    cyc("t6_keep2",2'b11, 2'b00, 1'b0, 2'b10);
    cyc("t6_keep3",2'b11, 2'b10, 1'b0, 2'b10);
    cyc("t6_gap",  2'b11, 2'b00, 1'b0, 2'b00);
`endif
    cyc("end_g0",  2'b10, 2'b01, 1'b0, 2'b01);
    cyc("end_rel", 2'b00, 2'b11, 1'b0, 2'b00);
    cyc("end_idl", 2'b00, 2'b00, 1'b0, 2'b00);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
